// File: rtl/cpu_eu_pkg.sv
// Shared definitions for the sequenced execution unit: opcode values,
// FSM state encoding and instruction field extraction.
package cpu_eu_pkg;

    // Widest instruction word the field extractor handles
    localparam int MAX_W = 64;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_ST  = 4'hD;
    localparam logic [3:0] OP_JZ  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } eu_state_t;

    // Extract 'width' bits starting at bit 'lsb' of an instruction word
    function automatic logic [MAX_W-1:0] f_field(input logic [MAX_W-1:0] word,
                                                 input int lsb,
                                                 input int width);
        logic [MAX_W-1:0] mask_v;
        mask_v = {MAX_W{1'b1}} >> (MAX_W - width);
        return (word >> lsb) & mask_v;
    endfunction

endpackage

// File: rtl/eu_alu.sv
// Combinational ALU: computes the result and C/N/Z for opcodes MOV..SHR.
// C is carry-out for ADD/INC, borrow for SUB/DEC, the shifted-out bit for
// shifts and zero for the logic ops and MOV.
module eu_alu
    import cpu_eu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              n,
    output logic              z
);

    logic [DATA_W:0] ext_s;
    logic            carry_s;

    // Compute the extended result; the extra top bit holds carry/borrow/shift-out
    always_comb begin
        ext_s   = {(DATA_W+1){1'b0}};
        carry_s = 1'b0;
        case (op)
            OP_MOV: ext_s = {1'b0, b};
            OP_ADD: begin
                ext_s   = {1'b0, a} + {1'b0, b};
                carry_s = ext_s[DATA_W];
            end
            OP_SUB: begin
                ext_s   = {1'b0, a} - {1'b0, b};
                carry_s = ext_s[DATA_W];
            end
            OP_AND: ext_s = {1'b0, a & b};
            OP_OR:  ext_s = {1'b0, a | b};
            OP_XOR: ext_s = {1'b0, a ^ b};
            OP_NOT: ext_s = {1'b0, ~b};
            OP_INC: begin
                ext_s   = {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
                carry_s = ext_s[DATA_W];
            end
            OP_DEC: begin
                ext_s   = {1'b0, b} - {{DATA_W{1'b0}}, 1'b1};
                carry_s = ext_s[DATA_W];
            end
            OP_SHL: begin
                ext_s   = {b, 1'b0};
                carry_s = b[DATA_W-1];
            end
            OP_SHR: begin
                ext_s   = {2'b00, b[DATA_W-1:1]};
                carry_s = b[0];
            end
            default: begin
                ext_s   = {(DATA_W+1){1'b0}};
                carry_s = 1'b0;
            end
        endcase
        result = ext_s[DATA_W-1:0];
        c      = carry_s;
        n      = ext_s[DATA_W-1];
        z      = (ext_s[DATA_W-1:0] == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/cpu_eu_seq.sv
// Self-sequencing execution unit: PC, IR, register file and flags driven by
// a FETCH/EXEC/MEM/HALT state machine talking to memory over req/ack.
module cpu_eu_seq
    import cpu_eu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NREGS    = 8,
    parameter logic [DATA_W-1:0] RESET_PC = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              c_flag,
    output logic              n_flag,
    output logic              z_flag,
    output logic              halted
);

    localparam int RA_W = $clog2(NREGS);

    if (DATA_W < 4 + 3*RA_W) begin : g_width_check
        $error("cpu_eu_seq: DATA_W too narrow for opcode plus three register fields");
    end
    if ((1 << RA_W) != NREGS) begin : g_nregs_check
        $error("cpu_eu_seq: NREGS must be a power of two");
    end

    eu_state_t         state_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic              c_r;
    logic              n_r;
    logic              z_r;
    logic              halted_r;
    logic [DATA_W-1:0] regs_r [NREGS];

    logic [3:0]        op_s;
    logic [RA_W-1:0]   d_s;
    logic [RA_W-1:0]   r_s;
    logic [RA_W-1:0]   s_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_c_s;
    logic              alu_n_s;
    logic              alu_z_s;

    assign op_s = 4'(f_field(MAX_W'(ir_r), DATA_W - 4, 4));
    assign d_s  = RA_W'(f_field(MAX_W'(ir_r), 2*RA_W, RA_W));
    assign r_s  = RA_W'(f_field(MAX_W'(ir_r), RA_W, RA_W));
    assign s_s  = RA_W'(f_field(MAX_W'(ir_r), 0, RA_W));

    eu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_s),
        .a      (regs_r[r_s]),
        .b      (regs_r[s_s]),
        .result (alu_res_s),
        .c      (alu_c_s),
        .n      (alu_n_s),
        .z      (alu_z_s)
    );

    // Sequencer: state, PC, IR, flags, halt indication and register write-back
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_FETCH;
            pc_r     <= RESET_PC;
            ir_r     <= {DATA_W{1'b0}};
            c_r      <= 1'b0;
            n_r      <= 1'b0;
            z_r      <= 1'b0;
            halted_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (run && mem_ack) begin
                        ir_r    <= mem_rdata;
                        pc_r    <= pc_r + DATA_W'(1);
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_NOP: state_r <= ST_FETCH;
                        OP_LD, OP_ST: state_r <= ST_MEM;
                        OP_JZ: begin
                            if (z_r) begin
                                pc_r <= regs_r[r_s];
                            end
                            state_r <= ST_FETCH;
                        end
                        OP_HLT: begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                        default: begin
                            regs_r[d_s] <= alu_res_s;
                            c_r         <= alu_c_s;
                            n_r         <= alu_n_s;
                            z_r         <= alu_z_s;
                            state_r     <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (op_s == OP_LD) begin
                            regs_r[d_s] <= mem_rdata;
                        end
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    // Memory strobes decode the registered state so a zero-wait ack completes this cycle
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_r;
        mem_wdata = regs_r[s_s];
        if (!reset) begin
            mem_req = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req  = run;
                    mem_addr = pc_r;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = (op_s == OP_ST);
                    mem_addr = regs_r[r_s];
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign pc     = pc_r;
    assign ir     = ir_r;
    assign c_flag = c_r;
    assign n_flag = n_r;
    assign z_flag = z_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_cpu_eu_seq.sv
// Directed bench for cpu_eu_seq: the bench plays the memory, feeding one
// instruction per table entry and checking the resulting bus traffic,
// PC, flags and fetch latency against hand-computed values.
module tb_cpu_eu_seq;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        c_flag;
    logic        n_flag;
    logic        z_flag;
    logic        halted;

    cpu_eu_seq #(
        .DATA_W   (16),
        .NREGS    (8),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .ir        (ir),
        .c_flag    (c_flag),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          waits;
        logic        mem_op;
        logic        exp_we;
        logic [15:0] exp_maddr;
        logic [15:0] exp_wdata;
        logic [15:0] ldval;
        logic [15:0] exp_pc;
        logic [2:0]  exp_cnz;
        logic        halt;
    } vec_t;

    vec_t        vecs [28];
    int          n_tests;
    int          n_fail;
    logic [15:0] cur_pc;
    logic [15:0] last_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Serve one instruction fetch with the given number of wait cycles
    task automatic do_fetch(input logic [15:0] word, input int waits, input logic [15:0] exp_addr);
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_we", {31'd0, mem_we}, 32'd0);
        chk("fetch_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
            chk("wait_ir", {16'd0, ir}, {16'd0, last_ir});
        end
        mem_rdata = word;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        last_ir   = word;
        chk("ir_load", {16'd0, ir}, {16'd0, word});
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        do_fetch(v.instr, v.waits, cur_pc);
        tick();
        if (v.mem_op) begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, v.exp_maddr});
            if (v.exp_we) begin
                chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.exp_wdata});
            end
            mem_rdata = v.ldval;
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
        end
        chk($sformatf("v%0d_pc", i), {16'd0, pc}, {16'd0, v.exp_pc});
        chk($sformatf("v%0d_cnz", i), {29'd0, c_flag, n_flag, z_flag}, {29'd0, v.exp_cnz});
        chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, v.halt});
        chk($sformatf("v%0d_next_req", i), {31'd0, mem_req}, {31'd0, ~v.halt});
        cur_pc = v.exp_pc;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        run       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        cur_pc    = 16'h0000;
        last_ir   = 16'h0000;

        // instr, waits, mem_op, we, maddr, wdata, ldval, exp_pc, cnz, halt
        vecs[0]  = '{16'h8000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 3'b000, 1'b0};
        vecs[1]  = '{16'h2048, 3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 3'b000, 1'b0};
        vecs[2]  = '{16'h3118, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 3'b110, 1'b0};
        vecs[3]  = '{16'hC058, 0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0004, 3'b110, 1'b0};
        vecs[4]  = '{16'hC098, 1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0005, 3'b110, 1'b0};
        vecs[5]  = '{16'hD00A, 0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0006, 3'b110, 1'b0};
        vecs[6]  = '{16'hC088, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h0007, 3'b110, 1'b0};
        vecs[7]  = '{16'hD01A, 0, 1'b1, 1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h0008, 3'b110, 1'b0};
        vecs[8]  = '{16'h4154, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0009, 3'b000, 1'b0};
        vecs[9]  = '{16'h616D, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 3'b001, 1'b0};
        vecs[10] = '{16'hE008, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 3'b001, 1'b0};
        vecs[11] = '{16'hA184, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 3'b110, 1'b0};
        vecs[12] = '{16'hE008, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 3'b110, 1'b0};
        vecs[13] = '{16'hB180, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0013, 3'b101, 1'b0};
        vecs[14] = '{16'h51D0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0014, 3'b000, 1'b0};
        vecs[15] = '{16'h71C7, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0015, 3'b010, 1'b0};
        vecs[16] = '{16'h90C3, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0016, 3'b110, 1'b0};
        vecs[17] = '{16'h80C3, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0017, 3'b101, 1'b0};
        vecs[18] = '{16'h1147, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 3'b010, 1'b0};
        vecs[19] = '{16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0019, 3'b010, 1'b0};
        vecs[20] = '{16'h217F, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h001A, 3'b110, 1'b0};
        vecs[21] = '{16'h316D, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h001B, 3'b001, 1'b0};
        vecs[22] = '{16'hF000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h001C, 3'b001, 1'b1};
        vecs[23] = '{16'hC040, 0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 3'b000, 1'b0};
        vecs[24] = '{16'h6092, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 3'b001, 1'b0};
        vecs[25] = '{16'hE008, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 3'b001, 1'b0};
        vecs[26] = '{16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b0};
        vecs[27] = '{16'hD003, 0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 3'b000, 1'b0};

        // Reset held for three cycles with run high
        repeat (3) tick();
        chk("rst_pc", {16'd0, pc}, 32'd0);
        chk("rst_ir", {16'd0, ir}, 32'd0);
        chk("rst_flags", {29'd0, c_flag, n_flag, z_flag}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        #1;

        // Main program: ALU, wait states, LD/ST, JZ taken/not taken, HLT
        for (int i = 0; i <= 22; i++) begin
            run_vec(i);
        end

        // Halted: no requests for ten cycles even with ack asserted
        mem_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("halt_noreq", {31'd0, mem_req}, 32'd0);
            chk("halt_flag", {31'd0, halted}, 32'd1);
        end
        mem_ack = 1'b0;
        chk("halt_pc", {16'd0, pc}, 32'h001C);

        // Reset out of HALT, then drive PC to 0xFFFF and check wrap
        reset = 1'b0;
        tick();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_pc", {16'd0, pc}, 32'd0);
        reset   = 1'b1;
        #1;
        cur_pc  = 16'h0000;
        last_ir = 16'h0000;
        for (int i = 23; i <= 26; i++) begin
            run_vec(i);
        end

        // Stall with run low: no request, ack ignored, PC and IR hold
        run     = 1'b0;
        mem_ack = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_req", {31'd0, mem_req}, 32'd0);
            tick();
        end
        chk("stall_pc", {16'd0, pc}, 32'd0);
        chk("stall_ir", {16'd0, ir}, 32'd0);
        mem_ack = 1'b0;
        run     = 1'b1;
        #1;

        // Reset during a withheld LD: request drops, no write-back of the read data
        do_fetch(16'hC0C0, 0, 16'h0000);
        tick();
        chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
        chk("ld_mem_addr", {16'd0, mem_addr}, 32'd0);
        mem_rdata = 16'h5555;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_req_low", {31'd0, mem_req}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("abort_pc", {16'd0, pc}, 32'd0);
        chk("abort_ir", {16'd0, ir}, 32'd0);
        chk("abort_fetch_req", {31'd0, mem_req}, 32'd1);
        cur_pc  = 16'h0000;
        last_ir = 16'h0000;
        run_vec(27);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
